// File: rtl/branch_predictor_if.sv
// Fetch/resolve port bundle for the branch predictor.
// The master side drives the fetch PC and the ID-stage resolution. The slave side returns the prediction and the statistics.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_vld;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_tgt;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] miss_count;

  modport master (
    output fetch_pc, upd_vld, upd_pc, upd_taken, upd_tgt, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, branch_count, miss_count
  );

  modport slave (
    input  fetch_pc, upd_vld, upd_pc, upd_taken, upd_tgt, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, branch_count, miss_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direction predictor (2-bit saturating counters) plus tagged target buffer. The prediction is combinational with zero latency.
// Training commits on the clock edge and the mispredict output is a registered pulse. There is no backpressure: every update is accepted.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          ctr;
    logic [31:0]         target;
  } entry_t;

  localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, ctr: 2'b01, target: 32'h0};

  entry_t bht_q [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx, upd_idx;
  logic [TAG_BITS-1:0] fetch_tag, upd_tag;
  logic                fetch_hit, upd_hit, upd_miss;
  logic [1:0]          upd_ctr, ctr_inc, ctr_dec;
  logic                mispredict_q;
  logic [31:0]         branch_count_q, miss_count_q;

  assign fetch_idx = bp.fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = bp.fetch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx   = bp.upd_pc[IDX_BITS+1:2];
  assign upd_tag   = bp.upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Reads see pre-edge contents; a same-cycle update is visible only after the edge.
  assign fetch_hit      = bht_q[fetch_idx].valid && (bht_q[fetch_idx].tag == fetch_tag);
  assign bp.pred_taken  = fetch_hit && bht_q[fetch_idx].ctr[1];
  assign bp.pred_target = bp.pred_taken ? bht_q[fetch_idx].target : 32'h0;

  assign upd_hit  = bht_q[upd_idx].valid && (bht_q[upd_idx].tag == upd_tag);
  assign upd_ctr  = bht_q[upd_idx].ctr;
  assign ctr_inc  = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
  assign ctr_dec  = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
  assign upd_miss = (bp.upd_taken != bp.upd_pred_taken) ||
                    (bp.upd_taken && bp.upd_pred_taken && (bp.upd_pred_target != bp.upd_tgt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= ENTRY_RST;
    end else if (bp.upd_vld) begin
      if (upd_hit) begin
        bht_q[upd_idx].ctr <= bp.upd_taken ? ctr_inc : ctr_dec;
        if (bp.upd_taken) bht_q[upd_idx].target <= bp.upd_tgt;
      end else if (bp.upd_taken) begin
        // Taken miss allocates, evicting whatever aliased into this index.
        bht_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, ctr: 2'b10, target: bp.upd_tgt};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q   <= 1'b0;
      branch_count_q <= 32'h0;
      miss_count_q   <= 32'h0;
    end else begin
      mispredict_q <= bp.upd_vld && upd_miss;
      if (bp.upd_vld) begin
        branch_count_q <= branch_count_q + 32'd1;
        if (upd_miss) miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign bp.mispredict   = mispredict_q;
  assign bp.branch_count = branch_count_q;
  assign bp.miss_count   = miss_count_q;

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, bp.fetch_pc[1:0], bp.fetch_pc[31:IDX_BITS+TAG_BITS+2],
                            bp.upd_pc[1:0], bp.upd_pc[31:IDX_BITS+TAG_BITS+2]};
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed spec scenarios plus randomized traffic against a table model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  branch_predictor_if bp();

  branch_predictor #(.IDX_BITS(6), .TAG_BITS(8)) dut (.clk(clk), .rst_n(rst_n), .bp(bp));

  always #5 clk = ~clk;

  // Reference table: index = pc[7:2], tag = pc[15:8], counter kept as an integer 0..3.
  bit          m_valid [64];
  logic [7:0]  m_tag   [64];
  int          m_ctr   [64];
  logic [31:0] m_tgt   [64];
  bit          m_misp;
  logic [31:0] m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 8'h0; m_ctr[i] = 1; m_tgt[i] = 32'h0;
    end
    m_misp = 1'b0; m_bc = 32'h0; m_mc = 32'h0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[pc[7:2]] && (m_tag[pc[7:2]] == pc[15:8]);
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[pc[7:2]] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    return exp_taken(pc) ? m_tgt[pc[7:2]] : 32'h0;
  endfunction

  function automatic void model_commit(input bit vld, input logic [31:0] pc, input bit tk,
                                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    int i;
    bit wrong;
    i = int'(pc[7:2]);
    if (!vld) begin
      m_misp = 1'b0;
      return;
    end
    wrong = (tk != ptk) || (tk && ptk && (ptgt != tgt));
    if (m_hit(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1; m_tag[i] = pc[15:8]; m_ctr[i] = 2; m_tgt[i] = tgt;
    end
    m_misp = wrong;
    m_bc = m_bc + 32'd1;
    if (wrong) m_mc = m_mc + 32'd1;
  endfunction

  task automatic drive(input logic [31:0] fpc, input bit vld, input logic [31:0] upc, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    @(negedge clk);
    bp.fetch_pc = fpc; bp.upd_vld = vld; bp.upd_pc = upc; bp.upd_taken = tk;
    bp.upd_tgt = tgt; bp.upd_pred_taken = ptk; bp.upd_pred_target = ptgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit(bp.upd_vld, bp.upd_pc, bp.upd_taken, bp.upd_tgt, bp.upd_pred_taken, bp.upd_pred_target);
    #1;
  endtask

  // Resolve pc with the prediction the fetch stage would have carried for it.
  task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    drive(pc, 1'b1, pc, tk, tgt, exp_taken(pc), exp_target(pc));
    tick();
  endtask

  task automatic test_reset();
    bp.fetch_pc = 32'h0040_0010; bp.upd_vld = 1'b0; bp.upd_pc = 32'h0; bp.upd_taken = 1'b0;
    bp.upd_tgt = 32'h0; bp.upd_pred_taken = 1'b0; bp.upd_pred_target = 32'h0;
    model_reset();
    #12;
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%b want=0", bp.pred_taken); end
    total++; if (bp.pred_target !== 32'h0) begin bad++; $display("FAIL reset_pred_target got=%h want=0", bp.pred_target); end
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%b want=0", bp.mispredict); end
    total++; if (bp.branch_count !== 32'h0 || bp.miss_count !== 32'h0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", bp.branch_count, bp.miss_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_train();
    drive(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    tick();
    total++; if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL train_mispredict got=%b want=1", bp.mispredict); end
    total++; if (bp.miss_count !== 32'd1 || bp.branch_count !== 32'd1) begin
      bad++; $display("FAIL train_counts got=%0d/%0d want=1/1", bp.branch_count, bp.miss_count);
    end
    drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h0040_0100) begin
      bad++; $display("FAIL train_predict got=%b/%h want=1/00400100", bp.pred_taken, bp.pred_target);
    end
    tick();
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL train_misp_clear got=%b want=0", bp.mispredict); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) resolve(32'h0040_0010, 1'b1, 32'h0040_0100);
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL sat_correct_misp got=%b want=0", bp.mispredict); end
    resolve(32'h0040_0010, 1'b0, 32'h0);
    total++; if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL sat_nt_misp got=%b want=1", bp.mispredict); end
    drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL sat_ctr10_pred got=%b want=1", bp.pred_taken); end
    tick();
    resolve(32'h0040_0010, 1'b0, 32'h0);
    drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
      bad++; $display("FAIL sat_ctr01_pred got=%b/%h want=0/0", bp.pred_taken, bp.pred_target);
    end
    tick();
  endtask

  task automatic test_alias();
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100);
    // 0x0050_0010 differs only above the tag field, so it shares index and tag.
    drive(32'h0050_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (bp.pred_taken !== exp_taken(32'h0050_0010)) begin
      bad++; $display("FAIL alias_trunc_pred got=%b want=%b", bp.pred_taken, exp_taken(32'h0050_0010));
    end
    tick();
    drive(32'h0040_1010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL alias_diff_tag got=%b want=0", bp.pred_taken); end
    tick();
    resolve(32'h0040_1010, 1'b1, 32'h0040_0800);
    drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted got=%b want=0", bp.pred_taken); end
    tick();
  endtask

  task automatic test_same_cycle();
    drive(32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL same_pre_edge got=%b want=0", bp.pred_taken); end
    tick();
    total++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h0040_0200) begin
      bad++; $display("FAIL same_post_edge got=%b/%h want=1/00400200", bp.pred_taken, bp.pred_target);
    end
    drive(32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
    tick();
    total++; if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL wrong_target_misp got=%b want=1", bp.mispredict); end
    total++; if (bp.pred_target !== 32'h0040_0300) begin
      bad++; $display("FAIL wrong_target_new got=%h want=00400300", bp.pred_target);
    end
  endtask

  task automatic test_random();
    logic [31:0] upc, fpc, tgt, ptgt;
    bit vld, tk, ptk;
    for (int n = 0; n < 400; n++) begin
      upc = 32'h0040_0000 | ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
      fpc = 32'h0040_0000 | ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
      vld = ($urandom_range(0, 3) != 0);
      tk = $urandom_range(0, 1);
      tgt = upc + ($urandom_range(1, 2) << 8);
      ptk = exp_taken(upc) ^ ($urandom_range(0, 7) == 0);
      ptgt = exp_target(upc);
      drive(fpc, vld, upc, tk, tgt, ptk, ptgt);
      total++; if (bp.pred_taken !== exp_taken(fpc) || bp.pred_target !== exp_target(fpc)) begin
        bad++; $display("FAIL rand_predict pc=%h got=%b/%h want=%b/%h", fpc, bp.pred_taken, bp.pred_target,
                        exp_taken(fpc), exp_target(fpc));
      end
      tick();
      total++; if (bp.mispredict !== m_misp || bp.branch_count !== m_bc || bp.miss_count !== m_mc) begin
        bad++; $display("FAIL rand_stats got=%b/%0d/%0d want=%b/%0d/%0d", bp.mispredict, bp.branch_count,
                        bp.miss_count, m_misp, m_bc, m_mc);
      end
    end
  endtask

  task automatic test_reset_mid();
    resolve(32'h0040_0040, 1'b1, 32'h0040_0900);
    resolve(32'h0040_0040, 1'b1, 32'h0040_0900);
    drive(32'h0040_0040, 1'b1, 32'h0040_0040, 1'b0, 32'h0, 1'b1, 32'h0040_0900);
    tick();
    #2;
    rst_n = 1'b0;
    bp.upd_vld = 1'b0;
    #1;
    model_reset();
    total++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
      bad++; $display("FAIL midreset_pred got=%b/%h want=0/0", bp.pred_taken, bp.pred_target);
    end
    total++; if (bp.mispredict !== 1'b0 || bp.branch_count !== 32'h0 || bp.miss_count !== 32'h0) begin
      bad++; $display("FAIL midreset_stats got=%b/%0d/%0d want=0/0/0", bp.mispredict, bp.branch_count, bp.miss_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(32'h0040_0000 | (k << 3), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++; if (bp.pred_taken !== 1'b0) begin
        bad++; $display("FAIL postreset_miss pc=%h got=%b want=0", bp.fetch_pc, bp.pred_taken);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_train();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
